// File: rtl/dcache_pkg.sv
// Shared constants for the direct-mapped write-back L1 data cache: geometry,
// address field positions and the controller state encoding.
`timescale 1ns/1ps
package dcache_pkg;

  localparam int LINE_NUM = 32;
  localparam int TAG_W    = 22;
  localparam int IDX_W    = 5;
  localparam int OFF_W    = 5;
  localparam int LINE_W   = 256;
  localparam int WORD_W   = 32;
  localparam int WSEL_W   = 3;

  localparam int TAG_LSB  = IDX_W + OFF_W;
  localparam int IDX_LSB  = OFF_W;
  localparam int WSEL_LSB = 2;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WRITEBACK = 2'd1;
  localparam logic [1:0] ST_REFILL    = 2'd2;
  localparam logic [1:0] ST_DONE      = 2'd3;

  function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                            input logic [IDX_W-1:0] idx);
    return {tag, idx, {OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Line storage: valid/dirty/tag/data per line, asynchronous read, synchronous
// word-merge or full-line write on a single shared index.
`timescale 1ns/1ps
module dcache_sram
  import dcache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic              word_we_i,
  input  logic [WSEL_W-1:0] word_sel_i,
  input  logic [WORD_W-1:0] word_data_i,
  input  logic              line_we_i,
  input  logic [TAG_W-1:0]  line_tag_i,
  input  logic [LINE_W-1:0] line_data_i,
  output logic              rd_valid_o,
  output logic              rd_dirty_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [LINE_W-1:0] rd_data_o
);

  logic [LINE_NUM-1:0] valid_q;
  logic [LINE_NUM-1:0] dirty_q;
  logic [TAG_W-1:0]    tag_q  [LINE_NUM];
  logic [LINE_W-1:0]   data_q [LINE_NUM];

  // NOTE: only valid/dirty take the reset; tag and data arrays stay unreset so they map onto plain RAM.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (line_we_i) begin
      tag_q[idx_i]  <= line_tag_i;
      data_q[idx_i] <= line_data_i;
    end else if (word_we_i) begin
      data_q[idx_i][word_sel_i*WORD_W +: WORD_W] <= word_data_i;
    end
  end

  assign rd_valid_o = valid_q[idx_i];
  assign rd_dirty_o = dirty_q[idx_i];
  assign rd_tag_o   = tag_q[idx_i];
  assign rd_data_o  = data_q[idx_i];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate D-cache controller: combinational
// word hits, pipeline stall on miss, write-back then refill over mem_* handshake.
`timescale 1ns/1ps
module dcache_controller
  import dcache_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         p1_req_i,
  input  logic         p1_write_i,
  input  logic [31:0]  p1_addr_i,
  input  logic [31:0]  p1_data_i,
  output logic [31:0]  p1_data_o,
  output logic         p1_stall_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i,
  output logic [255:0] mem_data_o,
  output logic [31:0]  mem_addr_o,
  output logic         mem_enable_o,
  output logic         mem_write_o
);

  logic [1:0]        state_q, state_d;
  logic [TAG_W-1:0]  req_tag_q, req_tag_d;
  logic [IDX_W-1:0]  req_idx_q, req_idx_d;

  logic [TAG_W-1:0]  p1_tag;
  logic [IDX_W-1:0]  p1_idx;
  logic [WSEL_W-1:0] p1_wsel;
  logic              addr_unused;

  logic              in_idle;
  logic              hit;
  logic [IDX_W-1:0]  sram_idx;
  logic              word_we;
  logic              line_we;
  logic              rd_valid;
  logic              rd_dirty;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_data;

  assign p1_tag      = p1_addr_i[TAG_LSB +: TAG_W];
  assign p1_idx      = p1_addr_i[IDX_LSB +: IDX_W];
  assign p1_wsel     = p1_addr_i[WSEL_LSB +: WSEL_W];
  assign addr_unused = ^p1_addr_i[1:0];

  // Outside IDLE the line is addressed by the latched index only.
  assign in_idle  = (state_q == ST_IDLE);
  assign sram_idx = in_idle ? p1_idx : req_idx_q;
  assign hit      = rd_valid & (rd_tag == p1_tag);
  assign word_we  = in_idle & p1_req_i & p1_write_i & hit;
  assign line_we  = (state_q == ST_REFILL) & mem_ack_i;

  dcache_sram u_sram (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .idx_i       (sram_idx),
    .word_we_i   (word_we),
    .word_sel_i  (p1_wsel),
    .word_data_i (p1_data_i),
    .line_we_i   (line_we),
    .line_tag_i  (req_tag_q),
    .line_data_i (mem_data_i),
    .rd_valid_o  (rd_valid),
    .rd_dirty_o  (rd_dirty),
    .rd_tag_o    (rd_tag),
    .rd_data_o   (rd_data)
  );

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    req_tag_d = req_tag_q;
    req_idx_d = req_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (p1_req_i && !hit) begin
          req_tag_d = p1_tag;
          req_idx_d = p1_idx;
          state_d   = (rd_valid && rd_dirty) ? ST_WRITEBACK : ST_REFILL;
        end
      end
      ST_WRITEBACK: if (mem_ack_i) state_d = ST_REFILL;
      ST_REFILL:    if (mem_ack_i) state_d = ST_DONE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      req_tag_q <= '0;
      req_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      req_tag_q <= req_tag_d;
      req_idx_q <= req_idx_d;
    end
  end

  // The victim line is untouched during write-back, so reading it live keeps the bus stable.
  always_comb begin
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    case (state_q)
      ST_WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = line_addr(rd_tag, req_idx_q);
        mem_data_o   = rd_data;
      end
      ST_REFILL: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = line_addr(req_tag_q, req_idx_q);
      end
      default: ;
    endcase
  end

  assign p1_data_o  = (in_idle && hit) ? rd_data[p1_wsel*WORD_W +: WORD_W] : '0;
  // Gated by reset so an abandoned transfer releases the pipeline immediately.
  assign p1_stall_o = rst_i & ((in_idle & p1_req_i & ~hit) | ~in_idle);

endmodule

// File: tb/tb_dcache_controller.sv
// Randomized bench for dcache_controller against a line-level cache/memory
// reference model, plus the directed reset, eviction and spurious-ack scenarios.
`timescale 1ns/1ps
module tb_dcache_controller;

  logic         clk;
  logic         rst_n;
  logic         p1_req;
  logic         p1_write;
  logic [31:0]  p1_addr;
  logic [31:0]  p1_wdata;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
  logic [255:0] mem_data_o;
  logic [31:0]  mem_addr_o;
  logic         mem_enable_o;
  logic         mem_write_o;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: cache contents per index and a sparse backing memory.
  bit           m_valid [32];
  bit           m_dirty [32];
  logic [21:0]  m_tag   [32];
  logic [255:0] m_data  [32];
  logic [255:0] mem     [int unsigned];

  dcache_controller dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .p1_req_i     (p1_req),
    .p1_write_i   (p1_write),
    .p1_addr_i    (p1_addr),
    .p1_data_i    (p1_wdata),
    .p1_data_o    (p1_data_o),
    .p1_stall_o   (p1_stall_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i),
    .mem_data_o   (mem_data_o),
    .mem_addr_o   (mem_addr_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    logic [255:0] l;
    if (!mem.exists(a)) begin
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
      mem[a] = l;
    end
    return mem[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  // One CPU access; memory answers the n-th cycle its enable is seen high.
  task automatic do_access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int wb_lat, input int rf_lat);
    int          idx, w, exp_stall, stall_cnt, en_cnt, phase, guard;
    logic [21:0] tg;
    bit          hit, need_wb;
    logic [31:0] wb_addr, rf_addr;
    logic [255:0] wb_line;
    idx       = int'(addr[9:5]);
    w         = int'(addr[4:2]);
    tg        = addr[31:10];
    hit       = m_valid[idx] && (m_tag[idx] == tg);
    need_wb   = !hit && m_valid[idx] && m_dirty[idx];
    wb_addr   = {m_tag[idx], addr[9:5], 5'b0};
    wb_line   = m_data[idx];
    rf_addr   = {addr[31:5], 5'b0};
    exp_stall = hit ? 0 : ((need_wb ? wb_lat : 0) + rf_lat + 2);
    phase     = need_wb ? 0 : 1;
    stall_cnt = 0;
    en_cnt    = 0;
    guard     = 0;

    @(negedge clk);
    p1_req   = 1'b1;
    p1_write = wr;
    p1_addr  = addr;
    p1_wdata = wdata;
    #1;
    while (p1_stall_o && guard < 300) begin
      stall_cnt++;
      if (phase == 2) begin
        check("enable_after_ack", mem_enable_o, 1'b0);
      end else if (mem_enable_o) begin
        if (phase == 0) begin
          check("wb_addr", mem_addr_o, wb_addr);
          check("wb_write", mem_write_o, 1'b1);
          check("wb_data", mem_data_o, wb_line);
        end else begin
          check("rf_addr", mem_addr_o, rf_addr);
          check("rf_write", mem_write_o, 1'b0);
        end
        en_cnt++;
        if (en_cnt == ((phase == 0) ? wb_lat : rf_lat)) begin
          mem_ack_i = 1'b1;
          en_cnt    = 0;
          if (phase == 0) begin
            mem[wb_addr] = wb_line;
          end else begin
            mem_data_i   = mem_line(rf_addr);
            m_data[idx]  = mem_data_i;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tg;
          end
          phase++;
        end
      end
      @(negedge clk);
      mem_ack_i  = 1'b0;
      mem_data_i = $urandom;
      #1;
      guard++;
    end
    check("stall_cycles", stall_cnt, exp_stall);
    if (!wr) begin
      check("load_data", p1_data_o, m_data[idx][w*32 +: 32]);
    end else begin
      m_data[idx][w*32 +: 32] = wdata;
      m_dirty[idx]            = 1'b1;
    end
    @(posedge clk);
    #1;
    p1_req = 1'b0;
  endtask

  initial begin
    logic [255:0] l40;
    logic [21:0]  tags [4];
    int           guard;
    rst_n      = 1'b0;
    p1_req     = 1'b0;
    p1_write   = 1'b0;
    p1_addr    = '0;
    p1_wdata   = '0;
    mem_data_i = '0;
    mem_ack_i  = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) l40[i*32 +: 32] = (i + 1) * 32'h11;
    mem[32'h40] = l40;

    // Reset state, including a pending request that must not stall.
    #12;
    check("rst_stall", p1_stall_o, 1'b0);
    check("rst_data", p1_data_o, 32'h0);
    check("rst_enable", mem_enable_o, 1'b0);
    check("rst_write", mem_write_o, 1'b0);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_mdata", mem_data_o, 256'h0);
    p1_req  = 1'b1;
    p1_addr = 32'h40;
    #1;
    check("rst_stall_req", p1_stall_o, 1'b0);
    p1_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed plan: first miss (12-cycle stall), hit, store hit, dirty eviction.
    do_access(1'b0, 32'h0000_0040, 32'h0, 1, 10);
    do_access(1'b0, 32'h0000_0044, 32'h0, 1, 1);
    do_access(1'b1, 32'h0000_0048, 32'hDEADBEEF, 1, 1);
    check("dirty_word2", m_data[2][95:64], 32'hDEADBEEF);
    do_access(1'b0, 32'h0000_0448, 32'h0, 3, 4);
    check("wb_mem_word2", mem[32'h40][95:64], 32'hDEADBEEF);
    do_access(1'b1, 32'h0000_0100, 32'hCAFE_F00D, 1, 2);
    do_access(1'b0, 32'h0000_0100, 32'h0, 1, 1);

    // Spurious ack while idle must not disturb anything.
    @(negedge clk);
    mem_ack_i  = 1'b1;
    mem_data_i = '1;
    @(negedge clk);
    mem_ack_i = 1'b0;
    #1;
    check("spurious_enable", mem_enable_o, 1'b0);
    check("spurious_stall", p1_stall_o, 1'b0);
    do_access(1'b0, 32'h0000_0100, 32'h0, 1, 1);
    do_access(1'b0, 32'h0000_0444, 32'h0, 1, 1);

    // Reset in the middle of a refill.
    @(negedge clk);
    p1_req   = 1'b1;
    p1_write = 1'b0;
    p1_addr  = 32'h40;
    guard    = 0;
    #1;
    while (!mem_enable_o && guard < 20) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check("mid_refill_enable", mem_enable_o, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_enable", mem_enable_o, 1'b0);
    check("mid_rst_stall", p1_stall_o, 1'b0);
    check("mid_rst_addr", mem_addr_o, 32'h0);
    @(negedge clk);
    p1_req = 1'b0;
    rst_n  = 1'b1;
    model_reset();
    do_access(1'b0, 32'h0000_0040, 32'h0, 1, 3);

    // Randomized traffic over a small tag pool to force conflicts.
    tags[0] = 22'h0;
    tags[1] = 22'h1;
    tags[2] = 22'h2A5;
    tags[3] = 22'h3FFFFF;
    for (int n = 0; n < 200; n++) begin
      logic [4:0]  idx;
      logic [2:0]  ws;
      logic [31:0] a;
      case ($urandom_range(0, 3))
        0:       idx = 5'd0;
        1:       idx = 5'd31;
        default: idx = 5'($urandom_range(0, 31));
      endcase
      ws = 3'($urandom_range(0, 7));
      a  = {tags[$urandom_range(0, 3)], idx, ws, 2'b00};
      do_access(1'($urandom_range(0, 1)), a, $urandom,
                $urandom_range(1, 5), $urandom_range(1, 5));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate L1 data-cache controller that sits between the CPU's MEM stage (EX/MEM address, write data, MemRead/MemWrite) and the 256-bit off-chip data-memory interface. It serves word hits combinationally, stalls the pipeline on a miss, and sequences write-back and refill line transfers over the `mem_*` enable/ack handshake. It replaces the direct memory hookup inside `CPU` and drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB stall inputs.

## Interface
- LINE_NUM, 32, number of cache lines; index width is log2(LINE_NUM).
- LINE_BYTES, 32, bytes per line; line is 256 bits, offset is 5 bits.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- p1_req_i  in  1  CPU access this cycle (MemRead | MemWrite).
- p1_write_i  in  1  1 = store word, 0 = load word.
- p1_addr_i  in  32  byte address, word-aligned; tag [31:10], index [9:5], word [4:2].
- p1_data_i  in  32  store data.
- p1_data_o  out  32  load data, valid when `p1_req_i & ~p1_stall_o`.
- p1_stall_o  out  1  freeze the pipeline.
- mem_data_i  in  256  refill line.
- mem_ack_i  in  1  memory completed the current request (1-cycle pulse).
- mem_data_o  out  256  write-back line.
- mem_addr_o  out  32  line address, bits [4:0] = 0.
- mem_enable_o  out  1  memory request active.
- mem_write_o  out  1  1 = write-back, 0 = refill.

## Operation
- Per line: valid, dirty, 22-bit tag, 256-bit data. Hit = `valid & (tag == p1_addr_i[31:10])`.
- FSM states: IDLE, WRITEBACK, REFILL, DONE.
- IDLE, no request: idle.
- IDLE, hit:
  - Load returns the selected word combinationally.
  - Store writes the word at the clock edge and sets dirty.
  - No stall.
- IDLE, miss: latch tag and index.
  - Victim valid & dirty: go to WRITEBACK.
  - Otherwise: go to REFILL.
- WRITEBACK:
  - Drives `mem_enable_o`=1, `mem_write_o`=1, `mem_addr_o`={victim tag, index, 5'b0}, `mem_data_o`= victim line.
  - On `mem_ack_i`, go to REFILL.
- REFILL:
  - Drives `mem_enable_o`=1, `mem_write_o`=0, `mem_addr_o`={latched tag, index, 5'b0}.
  - On `mem_ack_i`: write `mem_data_i` into the line, set valid=1, dirty=0, tag=latched tag; go to DONE.
- DONE: one cycle with stall still asserted, then IDLE. The access is now a hit and completes as a normal hit (write-allocate: the store merges in this IDLE cycle).
- `p1_stall_o` = `(state==IDLE & p1_req_i & ~hit) | (state != IDLE)`.
- Memory handshake:
  - `mem_enable_o`, `mem_addr_o`, `mem_write_o` and `mem_data_o` are stable from request start until the cycle `mem_ack_i` is sampled high.
  - `mem_enable_o` is low in the cycle after the ack.
  - `mem_ack_i` is ignored in IDLE and DONE.
- `p1_*` inputs are held stable by the stalled pipeline. The controller uses only the latched tag/index for memory addressing.

## Timing
- Reset (rst_i low, asynchronous):
  - State goes to IDLE; all valid and dirty bits clear; tags and data are not cleared.
  - `p1_stall_o`=0, `p1_data_o`=0, `mem_enable_o`=0, `mem_write_o`=0, `mem_addr_o`=0, `mem_data_o`=0.
  - Reset mid-transaction abandons the transfer; `mem_enable_o` drops immediately.
- Hit latency: 0 cycles (combinational data, store committed at the same edge).
- Clean miss:
  - Miss detected in cycle 0; `mem_enable_o` high from cycle 1.
  - Ack in cycle A.
  - DONE at A+1; hit completes at A+2.
  - Stall high in cycles 0..A+1.
- Dirty miss: as a clean miss, plus the write-back ack phase; refill enable rises the cycle after the write-back ack.
- Index wrap: indices 0 and 31 behave identically. Two addresses with the same index and different tag always evict.
- Ack in the same cycle the request is first raised is legal and accepted.

## Structure
- Shared package `dcache_pkg`:
  - State encoding (IDLE/WRITEBACK/REFILL/DONE).
  - TAG_W=22, IDX_W=5, OFF_W=5, LINE_W=256.
  - Field-slice constants for the address.
- Sub-module `dcache_sram`:
  - LINE_NUM entries of {valid, dirty, tag, data}.
  - Asynchronous read, synchronous write with a 32-bit word-write-enable path and a full-line write path.
  - Valid/dirty are cleared by rst_i.
- The FSM, hit compare, word select/merge and stall logic live in `dcache_controller`.

## Test plan
- Reset, then load 0x0000_0040 with memory returning line = {8 words 0x11..0x88}, ack 10 cycles after enable:
  - `mem_addr_o`=0x40, `mem_write_o`=0.
  - Stall for 12 cycles; `p1_data_o`=0x11.
- Same line, load 0x0000_0044:
  - No stall; `p1_data_o`=0x22 in the same cycle.
- Store 0xDEADBEEF to 0x0000_0048 (hit): dirty set, no stall. Then load 0x0000_0448 (same index 2, different tag):
  - Write-back with `mem_addr_o`=0x40, `mem_write_o`=1, word 2 of `mem_data_o`=0xDEADBEEF.
  - Then refill at 0x440.
- Store miss to 0x0000_0100 with a clean victim:
  - Refill, then the word merges.
  - A subsequent load returns the stored value with no stall.
- Assert rst_i low while in REFILL before the ack:
  - `mem_enable_o`=0 and `p1_stall_o`=0 immediately.
  - The next access to 0x40 misses.
- Spurious `mem_ack_i` pulse in IDLE: no state change, no line write.
